// File: rtl/rgst_stack_if.sv
// rgst_stack_if: operation request and stack status bundle for rgst_stack.
interface rgst_stack_if #(
    parameter int N = 16,
    parameter int DEPTH = 8,
    parameter int CW = $clog2(DEPTH + 1)
);
    logic en;
    logic [2:0] op;
    logic [N-1:0] d;
    logic [N-1:0] tos;
    logic [N-1:0] nos;
    logic [CW-1:0] count;
    logic empty;
    logic full;
    logic [1:0] err;
    modport master (output en, op, d, input tos, nos, count, empty, full, err);
    modport slave (input en, op, d, output tos, nos, count, empty, full, err);
endinterface

// File: rtl/rgst_stack.sv
// rgst_stack: register-file operand stack, one op per clock, sticky overflow/underflow flags.
module rgst_stack #(
    parameter int N = 16,
    parameter int DEPTH = 8,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst,
    rgst_stack_if.slave s
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] PUSH = 3'b001;
    localparam logic [2:0] POP = 3'b010;
    localparam logic [2:0] REPL = 3'b011;
    localparam logic [2:0] POPR = 3'b100;
    localparam logic [2:0] DUP = 3'b101;
    localparam logic [2:0] SWAP = 3'b110;
    localparam logic [2:0] CLR = 3'b111;
    logic [N-1:0] mem [DEPTH];
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0] err_q, err_n;
    logic [AW-1:0] pi, ti, ni, wa;
    logic [N-1:0] tos_v, nos_v, wa_d;
    logic wa_en, wb_en, ovf, unf, clr, is_full, is_empty, lt2;
    assign pi = AW'(cnt);
    assign ti = AW'(cnt - CW'(1));
    assign ni = AW'(cnt - CW'(2));
    assign is_full = cnt == CW'(DEPTH);
    assign is_empty = cnt == '0;
    assign lt2 = cnt < CW'(2);
    // Stale entries above count stay in the array; visibility is gated purely by count.
    assign tos_v = is_empty ? '0 : mem[ti];
    assign nos_v = lt2 ? '0 : mem[ni];
    always_comb begin
        cnt_n = cnt;
        ovf = 1'b0;
        unf = 1'b0;
        clr = 1'b0;
        wa_en = 1'b0;
        wb_en = 1'b0;
        wa = pi;
        wa_d = s.d;
        case (s.op)
            PUSH: if (is_full) ovf = 1'b1; else begin wa_en = 1'b1; cnt_n = cnt + CW'(1); end
            POP: if (is_empty) unf = 1'b1; else cnt_n = cnt - CW'(1);
            REPL: if (is_empty) unf = 1'b1; else begin wa_en = 1'b1; wa = ti; end
            POPR: if (lt2) unf = 1'b1; else begin wa_en = 1'b1; wa = ni; cnt_n = cnt - CW'(1); end
            DUP: begin
                ovf = is_full;
                unf = !is_full && is_empty;
                wa_en = !is_full && !is_empty;
                wa_d = tos_v;
                cnt_n = wa_en ? cnt + CW'(1) : cnt;
            end
            SWAP: if (lt2) unf = 1'b1; else begin wa_en = 1'b1; wb_en = 1'b1; wa = ti; wa_d = nos_v; end
            CLR: begin clr = 1'b1; cnt_n = '0; end
            default: ;
        endcase
        err_n = clr ? 2'b00 : err_q | {unf, ovf};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err_q <= 2'b00;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (s.en) begin
            cnt <= cnt_n;
            err_q <= err_n;
            if (wa_en) mem[wa] <= wa_d;
            if (wb_en) mem[ni] <= tos_v;
        end
    end
    assign s.tos = tos_v;
    assign s.nos = nos_v;
    assign s.count = cnt;
    assign s.empty = is_empty;
    assign s.full = is_full;
    assign s.err = err_q;
endmodule
